image_fetch_ctrl: RTL and testbench
===================================

IMAGE_FETCH_CTRL -- requirements
Module: image_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 784, number of pixels per frame.
REQ-002 The block SHALL have parameter ADDR_W, default 16, width of the image memory address.
REQ-003 The block SHALL have parameter DATA_W, default 32, width of one pixel word.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, a request to capture and stream one frame.
REQ-007 The block SHALL have port abort, input, 1, a request to cancel the current frame.
REQ-008 The block SHALL have port pixel_in, input, NUM_PIXELS, the raw pixel source (1 bit per pixel).
REQ-009 The block SHALL have port frame_out, output, NUM_PIXELS, the frozen frame driven to the image memory pixel_data.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W, the image memory read address.
REQ-011 The block SHALL have port mem_data, input, DATA_W, the image memory combinational read data.
REQ-012 The block SHALL have port out_data, output, DATA_W, the registered pixel word to the consumer.
REQ-013 The block SHALL have port out_valid, output, 1, meaning out_data holds a valid pixel.
REQ-014 The block SHALL have port out_ready, input, 1, consumer backpressure.
REQ-015 The block SHALL have port out_last, output, 1, marking the final pixel of the frame.
REQ-016 The block SHALL have port busy, output, 1, meaning the block is in any state other than IDLE.
REQ-017 The block SHALL have port done, output, 1, a one-cycle pulse after the last pixel transfers.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, STREAM and DONE.
REQ-019 In IDLE with start=1, the block SHALL register frame_out<=pixel_in, set mem_addr<=0 and enter LOAD.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 frame_out SHALL change only on the IDLE start edge; pixel_in changes mid-frame SHALL NOT affect streamed data.
REQ-022 In LOAD, the block SHALL register out_data<=mem_data for address 0, set out_idx<=0, mem_addr<=1 and out_valid<=1, then enter STREAM.
REQ-023 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_last, out_idx and mem_addr SHALL hold.
REQ-025 On a transfer with out_idx<NUM_PIXELS-1, the block SHALL set out_data<=mem_data, out_idx<=out_idx+1, mem_addr<=mem_addr+1 and keep out_valid=1, giving one pixel per cycle under continuous ready.
REQ-026 mem_addr SHALL saturate at NUM_PIXELS-1 and SHALL never present an address >= NUM_PIXELS.
REQ-027 out_last SHALL equal out_valid AND (out_idx==NUM_PIXELS-1).
REQ-028 On a transfer with out_last=1, the block SHALL clear out_valid and enter DONE.
REQ-029 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-030 Latency from the start edge to the first out_valid SHALL be 2 cycles; with out_ready held high, done SHALL rise NUM_PIXELS+2 cycles after start.
REQ-031 abort=1 in LOAD or STREAM SHALL clear out_valid on the next edge and return to IDLE without a done pulse; abort has priority over a same-cycle transfer.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 out_data SHALL be zero whenever out_valid=0 after IDLE is entered.

Reset
REQ-034 resetn=0 SHALL immediately force state=IDLE, frame_out=0, mem_addr=0, out_idx=0, out_data=0, out_valid=0, done=0 and busy=0.
REQ-035 A reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-036 The FSM state encoding and the NUM_PIXELS, ADDR_W and DATA_W defaults SHALL live in the shared project package.
REQ-037 The block SHALL be a single module with no sub-modules; the image memory SHALL be instantiated beside it by the parent.

Verification
REQ-038 The bench SHALL cover start with the checkerboard pattern pixel_in[i]=i%2 and out_ready=1: 784 words 0,1,0,1,... transfer, out_last coincides with word 783, done pulses at cycle 786.
REQ-039 The bench SHALL cover random out_ready at 30% duty: the word sequence is identical to the ready=1 case, with no duplicates or drops and out_data stable while stalled.
REQ-040 The bench SHALL cover pixel_in inverted at pixel 100: the streamed words still match the pixel_in value captured at start.
REQ-041 The bench SHALL cover abort at pixel 400: out_valid=0 next cycle, state IDLE, no done pulse, and a following start streams a full frame.
REQ-042 The bench SHALL cover start pulsed while busy and in DONE: it is ignored, and exactly one frame and one done pulse are produced.
REQ-043 The bench SHALL cover resetn low at pixel 250: all outputs are zero immediately, and no out_valid appears after release until start.

Source files
------------

// File: rtl/image_fetch_ctrl_pkg.sv
// Shared definitions for the image fetch controller: default geometry
// of the frame and image memory, and the controller state encoding.
package image_fetch_ctrl_pkg;

    localparam int NUM_PIXELS_DEF = 784;
    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } fetch_state_e;

    // True whenever the controller is working on (or finishing) a frame.
    function automatic logic state_is_busy(input fetch_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/image_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the image memory read port
// and the downstream pixel consumer (valid/ready stream).
interface image_fetch_ctrl_if
    import image_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Controller side: drives the memory address and the pixel stream.
    modport master (
        output mem_addr,
        input  mem_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    // Memory/consumer side.
    modport slave (
        input  mem_addr,
        output mem_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

endinterface

// File: rtl/image_fetch_ctrl.sv
// Image fetch controller: freezes one frame of raw pixels on start, then
// walks the image memory and streams one pixel word per accepted transfer.
module image_fetch_ctrl
    import image_fetch_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_PIXELS-1:0] pixel_in,
    output logic [NUM_PIXELS-1:0] frame_out,
    output logic                  busy,
    output logic                  done,
    image_fetch_ctrl_if.master    bus
);

    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] addr_inc_s;
    logic [IDX_W-1:0]  out_idx_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              xfer_s;
    logic              last_s;

    assign xfer_s = out_valid_r & bus.out_ready;
    assign last_s = out_valid_r & (out_idx_r == LAST_IDX);

    assign bus.mem_addr  = mem_addr_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = last_s;
    assign busy          = busy_r;
    assign done          = done_r;

    // Saturating address increment: never presents an address past the frame.
    always_comb begin
        addr_inc_s = mem_addr_r;
        if (mem_addr_r >= LAST_ADDR) begin
            addr_inc_s = LAST_ADDR;
        end else begin
            addr_inc_s = mem_addr_r + ADDR_W'(1);
        end
    end

    // Next-state logic; abort wins over a same-cycle transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (abort)                 state_nxt_s = ST_IDLE;
                else if (xfer_s && last_s) state_nxt_s = ST_DONE;
                else                       state_nxt_s = ST_STREAM;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Registered status flags, decoded from the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= state_is_busy(state_nxt_s);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Frame capture: the pixel source is frozen only on an accepted start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_out <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            frame_out <= pixel_in;
        end
    end

    // Stream datapath: address walk, output word register and pixel index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_addr_r  <= '0;
            out_idx_r   <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_data_r  <= '0;
                    out_valid_r <= 1'b0;
                    if (start) begin
                        mem_addr_r <= '0;
                        out_idx_r  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        out_data_r  <= '0;
                        out_valid_r <= 1'b0;
                    end else begin
                        out_data_r  <= bus.mem_data;
                        out_idx_r   <= '0;
                        mem_addr_r  <= addr_inc_s;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        out_data_r  <= '0;
                        out_valid_r <= 1'b0;
                    end else if (xfer_s && last_s) begin
                        out_data_r  <= '0;
                        out_valid_r <= 1'b0;
                    end else if (xfer_s) begin
                        out_data_r  <= bus.mem_data;
                        out_idx_r   <= out_idx_r + IDX_W'(1);
                        mem_addr_r  <= addr_inc_s;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    out_data_r  <= '0;
                    out_valid_r <= 1'b0;
                end
                default: begin
                    out_data_r  <= '0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Bench for image_fetch_ctrl: behavioural image memory, table of whole-frame
// scenarios, hand-written abort/reset sequences, and a scoreboard monitor.
module tb_image_fetch_ctrl;

    localparam int NP     = 784;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int BUDGET = 12000;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int pattern;      // 0 checkerboard, 1 all ones, 2 random
        bit rnd;          // 30% random out_ready
        int inv_at;       // invert pixel_in after this many words (-1 never)
        int busy_start;   // pulse start after this many words (-1 never)
        bit done_start;   // pulse start during the DONE cycle
        int exp_first_v;  // cycle of first out_valid after the start cycle
        int exp_done_cyc; // cycle of done pulse (-1 when ready is random)
        int exp_words;
    } vec_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [NP-1:0] pixel_in;
    logic [NP-1:0] frame_out;
    logic          busy;
    logic          done;

    image_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    image_fetch_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .pixel_in  (pixel_in),
        .frame_out (frame_out),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   xfer_cnt = 0;
    int   done_cnt = 0;
    bit   rnd_ready = 1'b0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memory: one pixel per word, combinational read of the frozen frame.
    int mem_idx;
    always_comb begin
        mem_idx = int'(bus.mem_addr);
        if (mem_idx < NP) bus.mem_data = DW'(frame_out[mem_idx]);
        else              bus.mem_data = '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(99) < 30);
        else           bus.out_ready = 1'b1;
    endtask

    // Monitor on the falling edge: scoreboard, stall stability, idle zeros, done.
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_addr;
    logic          held_last;
    bit            stall_prev = 1'b0;
    exp_t          e;
    always @(negedge clk) begin
        if (resetn) begin
            chk("addr_range", 64'(int'(bus.mem_addr) < NP), 64'(1));
            if (stall_prev && bus.out_valid) begin
                chk("stall_data", 64'(bus.out_data), 64'(held_data));
                chk("stall_addr", 64'(bus.mem_addr), 64'(held_addr));
                chk("stall_last", 64'(bus.out_last), 64'(held_last));
            end
            if (!bus.out_valid) begin
                chk("idle_zero", 64'({bus.out_data, bus.out_last}), 64'(0));
            end
            if (bus.out_valid && bus.out_ready && !abort) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("word", 64'(bus.out_data), 64'(e.data));
                    chk("last", 64'(bus.out_last), 64'(e.last));
                end
                xfer_cnt++;
            end
            stall_prev = bus.out_valid && !bus.out_ready && !abort;
            held_data  = bus.out_data;
            held_addr  = bus.mem_addr;
            held_last  = bus.out_last;
            if (done) begin
                done_cnt++;
                chk("done_sb_empty", 64'(sb.size()), 64'(0));
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Load a pattern, record the expected words, and issue the start pulse.
    task automatic start_frame(input int pattern);
        for (int i = 0; i < NP; i++) begin
            case (pattern)
                0:       pixel_in[i] = 1'(i % 2);
                1:       pixel_in[i] = 1'b1;
                default: pixel_in[i] = 1'($urandom_range(1));
            endcase
        end
        for (int i = 0; i < NP; i++) begin
            sb.push_back('{data: DW'(pixel_in[i]), last: (i == NP - 1)});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait until n words of the current frame have transferred (bounded).
    task automatic wait_words(input int base, input int n);
        int c;
        c = 0;
        while ((xfer_cnt - base) < n && c < BUDGET) begin
            tick();
            c++;
        end
        chk("wait_words", 64'((xfer_cnt - base) >= n), 64'(1));
    endtask

    // Run and check one whole frame described by a table entry.
    task automatic run_frame(input vec_t v);
        int  base, d0, cyc, first_v, done_cyc, extra_v;
        bit  inv_done, bs_done;
        base = xfer_cnt; d0 = done_cnt;
        first_v = -1; done_cyc = -1; extra_v = 0;
        inv_done = 1'b0; bs_done = 1'b0;
        rnd_ready = v.rnd;
        start_frame(v.pattern);
        cyc = 1;
        while (!done && cyc < BUDGET) begin
            if (bus.out_valid && first_v < 0) first_v = cyc;
            start = 1'b0;
            if (v.inv_at >= 0 && !inv_done && (xfer_cnt - base) >= v.inv_at) begin
                pixel_in = ~pixel_in;
                inv_done = 1'b1;
            end
            if (v.busy_start >= 0 && !bs_done && (xfer_cnt - base) >= v.busy_start) begin
                start = 1'b1;
                bs_done = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (done) done_cyc = cyc;
        chk("done_seen", 64'(done_cyc >= 0), 64'(1));
        rnd_ready = 1'b0;
        if (v.done_start) start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus.out_valid) extra_v++;
            tick();
        end
        chk("first_valid_cycle", 64'(first_v), 64'(v.exp_first_v));
        if (v.exp_done_cyc >= 0) chk("done_cycle", 64'(done_cyc), 64'(v.exp_done_cyc));
        chk("words", 64'(xfer_cnt - base), 64'(v.exp_words));
        chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        chk("no_extra_frame", 64'(extra_v), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    vec_t vecs[5];

    initial begin
        int base, d0, seen;
        vecs[0] = '{pattern: 0, rnd: 1'b0, inv_at: -1,  busy_start: -1,  done_start: 1'b0,
                    exp_first_v: 2, exp_done_cyc: NP + 2, exp_words: NP};
        vecs[1] = '{pattern: 0, rnd: 1'b1, inv_at: -1,  busy_start: -1,  done_start: 1'b0,
                    exp_first_v: 2, exp_done_cyc: -1,     exp_words: NP};
        vecs[2] = '{pattern: 0, rnd: 1'b0, inv_at: 100, busy_start: -1,  done_start: 1'b0,
                    exp_first_v: 2, exp_done_cyc: NP + 2, exp_words: NP};
        vecs[3] = '{pattern: 2, rnd: 1'b1, inv_at: 100, busy_start: -1,  done_start: 1'b0,
                    exp_first_v: 2, exp_done_cyc: -1,     exp_words: NP};
        vecs[4] = '{pattern: 1, rnd: 1'b0, inv_at: -1,  busy_start: 300, done_start: 1'b1,
                    exp_first_v: 2, exp_done_cyc: NP + 2, exp_words: NP};

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        pixel_in = '0; bus.out_ready = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data",  64'(bus.out_data),  64'(0));
        chk("rst_addr",  64'(bus.mem_addr),  64'(0));
        chk("rst_busy",  64'(busy),          64'(0));
        chk("rst_done",  64'(done),          64'(0));
        chk("rst_frame", 64'(frame_out == '0), 64'(1));
        tick(); tick();
        resetn = 1'b1;
        tick(); tick();

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Abort at pixel 400: valid drops next edge, no done, next frame is whole.
        base = xfer_cnt; d0 = done_cnt;
        start_frame(0);
        wait_words(base, 400);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_busy",  64'(busy),          64'(0));
        chk("abort_words", 64'(xfer_cnt - base), 64'(400));
        sb.delete();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        chk("abort_no_valid", 64'(seen), 64'(0));
        chk("abort_no_done",  64'(done_cnt - d0), 64'(0));
        run_frame(vecs[0]);

        // Reset at pixel 250: everything zero at once, quiet until a new start.
        base = xfer_cnt; d0 = done_cnt;
        start_frame(0);
        wait_words(base, 250);
        resetn = 1'b0;
        #1;
        chk("mrst_valid", 64'(bus.out_valid), 64'(0));
        chk("mrst_data",  64'(bus.out_data),  64'(0));
        chk("mrst_last",  64'(bus.out_last),  64'(0));
        chk("mrst_addr",  64'(bus.mem_addr),  64'(0));
        chk("mrst_busy",  64'(busy),          64'(0));
        chk("mrst_done",  64'(done),          64'(0));
        chk("mrst_frame", 64'(frame_out == '0), 64'(1));
        sb.delete();
        tick(); tick(); tick();
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid || busy) seen++;
            tick();
        end
        chk("mrst_quiet",   64'(seen), 64'(0));
        chk("mrst_no_done", 64'(done_cnt - d0), 64'(0));
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
